// File: rtl/jacaranda_pkg.sv
// Shared jacaranda-8 definitions: interrupt FSM states and vector/mask constants.
// Latency: n/a (declarations only). Backpressure: n/a.
package jacaranda_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int VEC_STRIDE_LOG2 = 2;
    localparam int GIE_BIT         = 7;

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU/peripheral-facing signal bundle of the interrupt controller.
// Latency: n/a (wires only). Backpressure: none; the CPU samples take_intr when it fires.
interface intr_ctrl_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0] irq;
    logic [7:0]       mask_wdata;
    logic             mask_we;
    logic [7:0]       pc_in;
    logic             boundary;
    logic             reti;
    logic             take_intr;
    logic [7:0]       intr_vector;
    logic             intr_en;
    logic [7:0]       ret_pc;
    logic [N_SRC-1:0] pending;
    logic [7:0]       mask;

    modport master (
        output irq, mask_wdata, mask_we, pc_in, boundary, reti,
        input  take_intr, intr_vector, intr_en, ret_pc, pending, mask
    );

    modport slave (
        input  irq, mask_wdata, mask_we, pc_in, boundary, reti,
        output take_intr, intr_vector, intr_en, ret_pc, pending, mask
    );
endinterface

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder over the masked request vector.
// Latency: combinational. Backpressure: none.
module intr_prio_enc #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [2:0]       src
);
    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        valid = 1'b0;
        src   = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                src   = 3'(i);
            end
        end
    end
endmodule

// File: rtl/intr_ctrl.sv
// Edge-latching interrupt controller: masks requests, redirects the CPU at a boundary, no nesting.
// Latency: boundary at T -> take_intr/intr_en/vector/ret_pc at T+1; reti at R -> intr_en low at R+1.
// Backpressure: none; takes wait for boundary & GIE & idle, requests stay pending meanwhile.
module intr_ctrl
    import jacaranda_pkg::*;
#(
    parameter int         N_SRC    = 4,
    parameter logic [7:0] VEC_BASE = 8'hF0
) (
    input  logic        clock,
    input  logic        reset_n,
    intr_ctrl_if.slave  bus
);
    state_t           state_q, state_d;
    logic [N_SRC-1:0] irq_prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [7:0]       mask_q, mask_d;
    logic [7:0]       ret_pc_q, ret_pc_d;
    logic [7:0]       intr_vector_q, intr_vector_d;
    logic             take_intr_q, take_intr_d;
    logic             intr_en;

    logic [N_SRC-1:0] irq_edge;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] win_oh;
    logic             req_vld;
    logic [2:0]       src;
    logic             take;

    assign irq_edge = bus.irq & ~irq_prev_q;
    assign req      = pending_q & mask_q[N_SRC-1:0];

    intr_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .req   (req),
        .valid (req_vld),
        .src   (src)
    );

    assign take   = (state_q == IDLE) && bus.boundary && mask_q[GIE_BIT] && req_vld;
    assign win_oh = take ? (N_SRC'(1) << src) : '0;

    // A fresh edge on the winning source is OR-ed in after the clear, so it survives.
    always_comb begin
        pending_d     = (pending_q & ~win_oh) | irq_edge;
        mask_d        = bus.mask_we ? bus.mask_wdata : mask_q;
        ret_pc_d      = take ? bus.pc_in : ret_pc_q;
        intr_vector_d = take ? 8'(VEC_BASE + ({5'd0, src} << VEC_STRIDE_LOG2)) : intr_vector_q;
        take_intr_d   = take;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take)     state_d = ACTIVE;
            ACTIVE:  if (bus.reti) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        intr_en = (state_q == ACTIVE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irq_prev_q    <= '0;
            pending_q     <= '0;
            mask_q        <= '0;
            ret_pc_q      <= '0;
            intr_vector_q <= '0;
            take_intr_q   <= 1'b0;
        end else begin
            irq_prev_q    <= bus.irq;
            pending_q     <= pending_d;
            mask_q        <= mask_d;
            ret_pc_q      <= ret_pc_d;
            intr_vector_q <= intr_vector_d;
            take_intr_q   <= take_intr_d;
        end
    end

    assign bus.take_intr   = take_intr_q;
    assign bus.intr_vector = intr_vector_q;
    assign bus.intr_en     = intr_en;
    assign bus.ret_pc      = ret_pc_q;
    assign bus.pending     = pending_q;
    assign bus.mask        = mask_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_intr_ctrl;
    logic clock;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    intr_ctrl_if #(.N_SRC(4)) bus ();

    intr_ctrl #(.N_SRC(4), .VEC_BASE(8'hF0)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.irq        = '0;
        bus.mask_wdata = '0;
        bus.mask_we    = 1'b0;
        bus.pc_in      = '0;
        bus.boundary   = 1'b0;
        bus.reti       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic write_mask(input logic [7:0] m);
        bus.mask_wdata = m;
        bus.mask_we    = 1'b1;
        tick();
        bus.mask_we    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.take_intr !== 1'b0) begin failures++; $display("FAIL reset_take got=%b exp=0", bus.take_intr); end
        checks++; if (bus.intr_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", bus.intr_en); end
        checks++; if (bus.pending !== 4'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0", bus.pending); end
        checks++; if (bus.mask !== 8'h00) begin failures++; $display("FAIL reset_mask got=%h exp=00", bus.mask); end
        checks++; if (bus.intr_vector !== 8'h00) begin failures++; $display("FAIL reset_vector got=%h exp=00", bus.intr_vector); end
        checks++; if (bus.ret_pc !== 8'h00) begin failures++; $display("FAIL reset_ret_pc got=%h exp=00", bus.ret_pc); end
        // Line held high through reset counts as an edge right after release.
        bus.irq = 4'b0001;
        reset_n = 1'b0;
        tick();
        checks++; if (bus.pending !== 4'h0) begin failures++; $display("FAIL reset_hold_pending got=%h exp=0", bus.pending); end
        reset_n = 1'b1;
        tick();
        checks++; if (bus.pending !== 4'h1) begin failures++; $display("FAIL reset_held_irq_edge got=%h exp=1", bus.pending); end
        bus.irq = '0;
    endtask

    task automatic test_basic_take();
        do_reset();
        write_mask(8'h81);
        checks++; if (bus.mask !== 8'h81) begin failures++; $display("FAIL basic_mask got=%h exp=81", bus.mask); end
        bus.irq = 4'b0001;
        tick();
        checks++; if (bus.pending !== 4'h1) begin failures++; $display("FAIL basic_pending_set got=%h exp=1", bus.pending); end
        bus.boundary = 1'b1;
        bus.pc_in    = 8'h23;
        tick();
        bus.boundary = 1'b0;
        checks++; if (bus.take_intr !== 1'b1) begin failures++; $display("FAIL basic_take got=%b exp=1", bus.take_intr); end
        checks++; if (bus.intr_vector !== 8'hF0) begin failures++; $display("FAIL basic_vector got=%h exp=f0", bus.intr_vector); end
        checks++; if (bus.intr_en !== 1'b1) begin failures++; $display("FAIL basic_en got=%b exp=1", bus.intr_en); end
        checks++; if (bus.ret_pc !== 8'h23) begin failures++; $display("FAIL basic_ret_pc got=%h exp=23", bus.ret_pc); end
        checks++; if (bus.pending !== 4'h0) begin failures++; $display("FAIL basic_pending_clr got=%h exp=0", bus.pending); end
        bus.pc_in = 8'h55;
        tick();
        checks++; if (bus.take_intr !== 1'b0) begin failures++; $display("FAIL basic_take_pulse got=%b exp=0", bus.take_intr); end
        checks++; if (bus.ret_pc !== 8'h23) begin failures++; $display("FAIL basic_ret_pc_hold got=%h exp=23", bus.ret_pc); end
        checks++; if (bus.intr_en !== 1'b1) begin failures++; $display("FAIL basic_en_hold got=%b exp=1", bus.intr_en); end
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        checks++; if (bus.intr_en !== 1'b0) begin failures++; $display("FAIL basic_reti_en got=%b exp=0", bus.intr_en); end
        bus.irq = '0;
    endtask

    task automatic test_priority();
        do_reset();
        write_mask(8'h86);
        bus.irq = 4'b0110;
        tick();
        bus.boundary = 1'b1;
        tick();
        bus.boundary = 1'b0;
        checks++; if (bus.take_intr !== 1'b1) begin failures++; $display("FAIL prio_take1 got=%b exp=1", bus.take_intr); end
        checks++; if (bus.intr_vector !== 8'hF4) begin failures++; $display("FAIL prio_vector1 got=%h exp=f4", bus.intr_vector); end
        checks++; if (bus.pending !== 4'h4) begin failures++; $display("FAIL prio_pending1 got=%h exp=4", bus.pending); end
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        checks++; if (bus.intr_en !== 1'b0) begin failures++; $display("FAIL prio_reti_en got=%b exp=0", bus.intr_en); end
        bus.boundary = 1'b1;
        tick();
        bus.boundary = 1'b0;
        checks++; if (bus.take_intr !== 1'b1) begin failures++; $display("FAIL prio_take2 got=%b exp=1", bus.take_intr); end
        checks++; if (bus.intr_vector !== 8'hF8) begin failures++; $display("FAIL prio_vector2 got=%h exp=f8", bus.intr_vector); end
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        bus.irq  = '0;
    endtask

    task automatic test_no_nesting();
        do_reset();
        write_mask(8'h89);
        bus.irq = 4'b0001;
        tick();
        bus.boundary = 1'b1;
        tick();
        checks++; if (bus.intr_vector !== 8'hF0) begin failures++; $display("FAIL nest_first_vector got=%h exp=f0", bus.intr_vector); end
        // Boundary kept high while the handler runs: the new edge must only pend.
        bus.irq = 4'b1001;
        tick();
        checks++; if (bus.take_intr !== 1'b0) begin failures++; $display("FAIL nest_no_take got=%b exp=0", bus.take_intr); end
        checks++; if (bus.pending !== 4'h8) begin failures++; $display("FAIL nest_pending got=%h exp=8", bus.pending); end
        tick();
        checks++; if (bus.take_intr !== 1'b0) begin failures++; $display("FAIL nest_no_take2 got=%b exp=0", bus.take_intr); end
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        checks++; if (bus.intr_en !== 1'b0) begin failures++; $display("FAIL nest_reti_en got=%b exp=0", bus.intr_en); end
        checks++; if (bus.take_intr !== 1'b0) begin failures++; $display("FAIL nest_reti_boundary got=%b exp=0", bus.take_intr); end
        tick();
        bus.boundary = 1'b0;
        checks++; if (bus.take_intr !== 1'b1) begin failures++; $display("FAIL nest_next_take got=%b exp=1", bus.take_intr); end
        checks++; if (bus.intr_vector !== 8'hFC) begin failures++; $display("FAIL nest_vector got=%h exp=fc", bus.intr_vector); end
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        bus.irq  = '0;
    endtask

    task automatic test_global_enable();
        do_reset();
        write_mask(8'h01);
        bus.irq = 4'b0001;
        tick();
        bus.boundary = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.take_intr !== 1'b0) begin failures++; $display("FAIL gie_off_take[%0d] got=%b exp=0", i, bus.take_intr); end
        end
        checks++; if (bus.pending !== 4'h1) begin failures++; $display("FAIL gie_pending got=%h exp=1", bus.pending); end
        // Mask write coincides with an evaluation that still sees GIE=0.
        bus.mask_wdata = 8'h81;
        bus.mask_we    = 1'b1;
        tick();
        bus.mask_we    = 1'b0;
        checks++; if (bus.take_intr !== 1'b0) begin failures++; $display("FAIL gie_write_cycle got=%b exp=0", bus.take_intr); end
        checks++; if (bus.mask !== 8'h81) begin failures++; $display("FAIL gie_mask got=%h exp=81", bus.mask); end
        tick();
        bus.boundary = 1'b0;
        checks++; if (bus.take_intr !== 1'b1) begin failures++; $display("FAIL gie_on_take got=%b exp=1", bus.take_intr); end
        checks++; if (bus.intr_vector !== 8'hF0) begin failures++; $display("FAIL gie_vector got=%h exp=f0", bus.intr_vector); end
        bus.irq = '0;
    endtask

    task automatic test_reset_mid_handler();
        // Entered while test_global_enable left the handler active.
        checks++; if (bus.intr_en !== 1'b1) begin failures++; $display("FAIL mid_pre_en got=%b exp=1", bus.intr_en); end
        bus.irq = 4'b0010;
        tick();
        bus.irq = '0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++; if (bus.intr_en !== 1'b0) begin failures++; $display("FAIL mid_en got=%b exp=0", bus.intr_en); end
        checks++; if (bus.pending !== 4'h0) begin failures++; $display("FAIL mid_pending got=%h exp=0", bus.pending); end
        checks++; if (bus.mask !== 8'h00) begin failures++; $display("FAIL mid_mask got=%h exp=00", bus.mask); end
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        checks++; if (bus.intr_en !== 1'b0) begin failures++; $display("FAIL mid_reti_en got=%b exp=0", bus.intr_en); end
        checks++; if (bus.take_intr !== 1'b0) begin failures++; $display("FAIL mid_reti_take got=%b exp=0", bus.take_intr); end
    endtask

    task automatic test_same_source_set_clear();
        do_reset();
        write_mask(8'h81);
        bus.irq = 4'b0001;
        tick();
        bus.irq = '0;
        tick();
        bus.irq      = 4'b0001;
        bus.boundary = 1'b1;
        tick();
        bus.boundary = 1'b0;
        checks++; if (bus.take_intr !== 1'b1) begin failures++; $display("FAIL same_take got=%b exp=1", bus.take_intr); end
        checks++; if (bus.pending !== 4'h1) begin failures++; $display("FAIL same_set_wins got=%h exp=1", bus.pending); end
        bus.irq = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_take();
        test_priority();
        test_no_nesting();
        test_global_enable();
        test_reset_mid_handler();
        test_same_source_set_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
